// File: rtl/bitstream_unpacker.sv
// bitstream_unpacker
//   Unpacks MEM_WIDTH-bit memory words into a stream of cfg_bitwidth-bit values, LSB-first,
//   sign- or zero-extended to MAX_BW bits. Supports a fully packed layout and a word-aligned
//   layout in which a value never straddles two words (the unused top bits of a word are skipped).
//   A run is started with i_start, emits i_cfg_num_vals values, then pulses o_done (with o_err when
//   the configuration was rejected).
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             latch i_cfg_* and begin a run (only honoured when idle)
//   i_cfg_bitwidth      value width, legal 1..MAX_BW
//   i_cfg_num_vals      number of values in the run
//   i_cfg_signed        1: sign-extend, 0: zero-extend
//   i_cfg_aligned       1: values never straddle words, 0: fully packed
//   i_in_valid/i_in_data/o_in_ready       memory-side word stream (bit 0 is the oldest bit)
//   o_out_valid/o_out_data/o_out_last/i_out_ready   value stream, o_out_last marks the final value
//   o_busy              high whenever a run (or its done cycle) is in progress
//   o_done, o_err       one-cycle end-of-run pulse, o_err flags a rejected configuration
module bitstream_unpacker #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned MAX_BW    = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [$clog2(MAX_BW):0] i_cfg_bitwidth,
    input  logic [CNT_WIDTH-1:0]   i_cfg_num_vals,
    input  logic                   i_cfg_signed,
    input  logic                   i_cfg_aligned,
    input  logic                   i_in_valid,
    input  logic [MEM_WIDTH-1:0]   i_in_data,
    output logic                   o_in_ready,
    output logic                   o_out_valid,
    output logic [MAX_BW-1:0]      o_out_data,
    output logic                   o_out_last,
    input  logic                   i_out_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int unsigned BW_W   = $clog2(MAX_BW) + 1;
    localparam int unsigned BUF_W  = 2 * MEM_WIDTH;
    localparam int unsigned FILL_W = $clog2(BUF_W) + 1;
    localparam int unsigned WP_W   = $clog2(MEM_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [BUF_W-1:0]     r_buf;
    logic [FILL_W-1:0]    r_fill;
    logic [WP_W-1:0]      r_word_pos;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_num_vals;
    logic [BW_W-1:0]      r_bw;
    logic                 r_signed;
    logic                 r_aligned;
    logic                 r_err;

    logic                 w_cfg_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    int                   w_rem;
    logic [FILL_W-1:0]    w_step;
    logic [WP_W-1:0]      w_word_pos_next;
    logic [BUF_W-1:0]     w_buf_shift;
    logic [BUF_W-1:0]     w_buf_next;
    logic [FILL_W-1:0]    w_fill_shift;
    logic [FILL_W-1:0]    w_fill_next;
    logic                 w_sign;
    logic [MAX_BW-1:0]    w_out_data;

    assign w_cfg_ok = (i_cfg_bitwidth != '0) && (i_cfg_bitwidth <= BW_W'(MAX_BW));

    // Handshake outputs depend on registers only.
    assign o_in_ready  = (r_state == StRun) && (r_fill <= FILL_W'(MEM_WIDTH));
    assign o_out_valid = (r_state == StRun) && (r_fill >= FILL_W'(r_bw));
    assign w_last      = o_out_valid && (r_cnt == r_num_vals - CNT_WIDTH'(1));
    assign o_out_last  = w_last;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StDone);
    assign o_err  = (r_state == StDone) && r_err;

    // Pop size. In aligned mode, when the next value would not fit in the rest of the current
    // word, the pad bits are dropped together with this value.
    always_comb begin
        w_rem           = int'(MEM_WIDTH) - int'(r_word_pos) - int'(r_bw);
        w_step          = FILL_W'(r_bw);
        w_word_pos_next = r_word_pos;
        if (r_aligned) begin
            if (w_rem < int'(r_bw)) begin
                w_step          = FILL_W'(int'(MEM_WIDTH) - int'(r_word_pos));
                w_word_pos_next = '0;
            end else begin
                w_word_pos_next = r_word_pos + WP_W'(r_bw);
            end
        end
    end

    // Shift first, then append the new word above the remaining valid bits. Bits at and above
    // fill are always zero, so an OR is enough to insert the word.
    always_comb begin
        w_buf_shift  = w_pop ? (r_buf >> w_step) : r_buf;
        w_fill_shift = w_pop ? (r_fill - w_step) : r_fill;
        w_buf_next   = w_buf_shift;
        w_fill_next  = w_fill_shift;
        if (w_push) begin
            w_buf_next  = w_buf_shift | ({{MEM_WIDTH{1'b0}}, i_in_data} << w_fill_shift);
            w_fill_next = w_fill_shift + FILL_W'(MEM_WIDTH);
        end
    end

    // Extension from bit bw-1.
    always_comb begin
        w_sign = 1'b0;
        for (int i = 0; i < int'(MAX_BW); i++) begin
            if (i == int'(r_bw) - 1) begin
                w_sign = r_buf[i];
            end
        end
        w_sign = w_sign & r_signed;
        for (int i = 0; i < int'(MAX_BW); i++) begin
            w_out_data[i] = (i < int'(r_bw)) ? r_buf[i] : w_sign;
        end
    end

    assign o_out_data = w_out_data;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (w_cfg_ok && (i_cfg_num_vals != '0)) ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_pop && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf      <= '0;
            r_fill     <= '0;
            r_word_pos <= '0;
            r_cnt      <= '0;
            r_num_vals <= '0;
            r_bw       <= '0;
            r_signed   <= 1'b0;
            r_aligned  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_bw       <= i_cfg_bitwidth;
                        r_num_vals <= i_cfg_num_vals;
                        r_signed   <= i_cfg_signed;
                        r_aligned  <= i_cfg_aligned;
                        r_cnt      <= '0;
                        r_err      <= !w_cfg_ok;
                    end
                end
                StRun: begin
                    r_buf  <= w_buf_next;
                    r_fill <= w_fill_next;
                    if (w_pop) begin
                        r_word_pos <= w_word_pos_next;
                        r_cnt      <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                StDone: begin
                    // Leftover bits of the run are discarded.
                    r_buf      <= '0;
                    r_fill     <= '0;
                    r_word_pos <= '0;
                    r_err      <= 1'b0;
                end
                default: begin
                    r_buf  <= '0;
                    r_fill <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_unpacker.sv
// Self-checking bench for bitstream_unpacker (MEM_WIDTH=32, MAX_BW=16, CNT_WIDTH=32).
// Expected values come from a bit-level reference model of the word list and are queued at
// start; a monitor pops and compares each accepted output value.
module tb_bitstream_unpacker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_bitwidth;
    logic [31:0] cfg_num_vals;
    logic        cfg_signed;
    logic        cfg_aligned;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pop_cyc = -10;

    bitstream_unpacker #(
        .MEM_WIDTH(32),
        .MAX_BW   (16),
        .CNT_WIDTH(32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_cfg_bitwidth(cfg_bitwidth),
        .i_cfg_num_vals(cfg_num_vals),
        .i_cfg_signed  (cfg_signed),
        .i_cfg_aligned (cfg_aligned),
        .i_in_valid    (in_valid),
        .i_in_data     (in_data),
        .o_in_ready    (in_ready),
        .o_out_valid   (out_valid),
        .o_out_data    (out_data),
        .o_out_last    (out_last),
        .i_out_ready   (out_ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Output monitor: scoreboard compare on every accepted value, hold check under backpressure.
    initial begin : monitor
        logic        hold_vld;
        logic [15:0] hold_data;
        logic        hold_last;
        exp_t        e;
        hold_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (hold_vld) begin
                    checks++;
                    assert (out_data === hold_data && out_last === hold_last) else begin
                        errors++;
                        $error("FAIL hold_stable: got %h/%b exp %h/%b", out_data, out_last,
                               hold_data, hold_last);
                    end
                end
                if (out_ready !== 1'b1) begin
                    hold_vld  = 1'b1;
                    hold_data = out_data;
                    hold_last = out_last;
                end else begin
                    hold_vld = 1'b0;
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL extra_value: got %h exp none", out_data);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        checks++;
                        assert (out_data === e.data) else begin
                            errors++;
                            $error("FAIL out_data: got %h exp %h", out_data, e.data);
                        end
                        checks++;
                        assert (out_last === e.last) else begin
                            errors++;
                            $error("FAIL out_last: got %b exp %b", out_last, e.last);
                        end
                        if (e.last) last_pop_cyc = cyc;
                    end
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    // Reference model: walk the concatenated word bits directly.
    task automatic model(input int bw, input int n, input bit sgn, input bit aln);
        int pos;
        pos = 0;
        for (int v = 0; v < n; v++) begin
            logic [15:0] val;
            exp_t        e;
            val = '0;
            for (int b = 0; b < bw; b++) begin
                int          idx;
                logic [31:0] w;
                logic [31:0] sh;
                idx = (pos + b) / 32;
                w   = (idx < wq.size()) ? wq[idx] : 32'h0;
                sh  = w >> ((pos + b) % 32);
                val = val | (16'(sh[0]) << b);
            end
            if (sgn && ((val >> (bw - 1)) & 16'h1) != 16'h0) begin
                val = val | ~((16'h1 << bw) - 16'h1);
            end
            pos += bw;
            if (aln && (pos % 32) + bw > 32) pos = (pos / 32 + 1) * 32;
            e.data = val;
            e.last = (v == n - 1);
            sb.push_back(e);
        end
    endtask

    // All input changes happen 1 time unit after a rising edge.
    task automatic begin_run(input int bw, input int n, input bit sgn, input bit aln);
        if (bw >= 1 && bw <= 16) model(bw, n, sgn, aln);
        cfg_bitwidth = 5'(bw);
        cfg_num_vals = 32'(n);
        cfg_signed   = sgn;
        cfg_aligned  = aln;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        // Mid-run config changes must not matter.
        cfg_bitwidth = 5'd3;
        cfg_num_vals = 32'd1;
        cfg_signed   = ~sgn;
        cfg_aligned  = ~aln;
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL push_timeout: in_ready got %b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_done(input bit exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL done_timeout: done got %b exp 1", done);
        end
        checks++;
        assert (err === exp_err) else begin
            errors++;
            $error("FAIL err_flag: got %b exp %b", err, exp_err);
        end
        checks++;
        assert (cyc === last_pop_cyc + 1) else begin
            errors++;
            $error("FAIL done_after_last: got cycle %0d exp %0d", cyc, last_pop_cyc + 1);
        end
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL values_missing: got %0d left exp 0", sb.size());
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        assert (done === 1'b0 && busy === 1'b0) else begin
            errors++;
            $error("FAIL done_pulse: done/busy got %b/%b exp 0/0", done, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic immediate_done(input bit exp_err);
        @(negedge clk);
        checks++;
        assert (done === 1'b1 && err === exp_err && out_valid === 1'b0) else begin
            errors++;
            $error("FAIL cfg_reject: done/err/out_valid got %b/%b/%b exp 1/%b/0", done, err,
                   out_valid, exp_err);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        assert (done === 1'b0 && busy === 1'b0) else begin
            errors++;
            $error("FAIL cfg_reject_idle: done/busy got %b/%b exp 0/0", done, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_words(input int bw, input int n, input bit sgn, input bit aln);
        begin_run(bw, n, sgn, aln);
        for (int i = 0; i < wq.size(); i++) push_word(wq[i]);
        wait_done(1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cfg_bitwidth = '0;
        cfg_num_vals = '0;
        cfg_signed   = 1'b0;
        cfg_aligned  = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert ({busy, done, err, in_ready, out_valid, out_last} === 6'b0) else begin
            errors++;
            $error("FAIL reset_ctrl: got %b exp 000000",
                   {busy, done, err, in_ready, out_valid, out_last});
        end
        checks++;
        assert (out_data === 16'h0) else begin
            errors++;
            $error("FAIL reset_data: got %h exp 0000", out_data);
        end
        @(posedge clk);
        #1;

        // Packed, unsigned, bw=5; value 7 straddles the two words. Also checks first-value latency.
        wq.delete();
        wq.push_back(32'h8C62_1084);
        wq.push_back(32'h0000_0421);
        begin_run(5, 12, 1'b0, 1'b0);
        push_word(wq[0]);
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL first_valid_latency: got %b exp 1", out_valid);
        end
        @(posedge clk);
        #1;
        push_word(wq[1]);
        wait_done(1'b0);

        // Aligned bw=5: 6 values per word, bits 31:30 skipped.
        wq.delete();
        wq.push_back(32'hC000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF)));
        wq.push_back(32'($urandom));
        run_words(5, 12, 1'b0, 1'b1);

        // Sign extension of 0b11111 and zero extension of the same field.
        wq.delete();
        wq.push_back(32'hFFFF_FFFF);
        run_words(5, 6, 1'b1, 1'b0);
        run_words(5, 6, 1'b0, 1'b0);

        // bw=16 both modes: two values per word.
        wq.delete();
        wq.push_back(32'h8001_7FFE);
        wq.push_back(32'($urandom));
        run_words(16, 4, 1'b1, 1'b0);
        run_words(16, 4, 1'b0, 1'b1);

        // Aligned bw=7 signed (4 pad bits per word), packed bw=3 signed.
        wq.delete();
        wq.push_back(32'($urandom));
        wq.push_back(32'($urandom));
        run_words(7, 8, 1'b1, 1'b1);
        run_words(3, 21, 1'b1, 1'b0);

        // Backpressure: out_ready low while the buffer fills.
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back(32'($urandom));
        out_ready = 1'b0;
        begin_run(5, 30, 1'b0, 1'b0);
        push_word(wq[0]);
        push_word(wq[1]);
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b0 && out_valid === 1'b1) else begin
            errors++;
            $error("FAIL backpressure: in_ready/out_valid got %b/%b exp 0/1", in_ready,
                   out_valid);
        end
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) push_word(wq[i]);
        wait_done(1'b0);

        // Rejected / empty configurations.
        wq.delete();
        begin_run(5, 0, 1'b0, 1'b0);
        immediate_done(1'b0);
        begin_run(0, 4, 1'b0, 1'b0);
        immediate_done(1'b1);
        begin_run(17, 4, 1'b0, 1'b0);
        immediate_done(1'b1);

        // Reset mid-run, then a clean run from an empty buffer.
        wq.delete();
        wq.push_back(32'($urandom));
        wq.push_back(32'($urandom));
        begin_run(5, 12, 1'b0, 1'b0);
        push_word(wq[0]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        assert (busy === 1'b0 && out_valid === 1'b0 && in_ready === 1'b0) else begin
            errors++;
            $error("FAIL mid_reset: busy/out_valid/in_ready got %b/%b/%b exp 0/0/0", busy,
                   out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        wq.delete();
        wq.push_back(32'h8C62_1084);
        wq.push_back(32'h0000_0421);
        run_words(5, 12, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
